// File: rtl/zia_chk_pkg.sv
// Shared types and constants for the ZIA stimulus source / response checker.
// The LFSR constants apply when ZIA_STIM_LFSR_EN is defined.
package zia_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_DRIVE,
        ST_PULSE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } chk_state_e;

    localparam int DUT_OUT_W  = 8;
    localparam int ERR_CNT_W  = 16;

    // Each FB's four outputs all follow one feedback bit taken from the other FB.
    localparam int FB1_FB_BIT = 6;
    localparam int FB2_FB_BIT = 1;
    localparam int FB1_LSB    = 0;
    localparam int FB1_MSB    = 3;
    localparam int FB2_LSB    = 4;
    localparam int FB2_MSB    = 7;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_SEED  = 32'hACE1_2345;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam int          LFSR_STEPS = 32;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/zia_pattern_gen.sv
// Maps a step index to the stim vector: all-ones, walking zero, all-ones and,
// with ZIA_STIM_LFSR_EN defined, a 32-step LFSR phase (every 4th step all-ones).
module zia_pattern_gen
    import zia_chk_pkg::*;
#(
    parameter int NUM_IN = 38,
    parameter int STEP_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_i,
    input  logic              load_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [NUM_IN-1:0] stim_o
);

    logic [NUM_IN-1:0] walk_stim;

    always_comb begin
        walk_stim = '1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (step_i == STEP_W'(k + 1)) begin
                walk_stim[k] = 1'b0;
            end
        end
    end

`ifdef ZIA_STIM_LFSR_EN
    localparam logic [STEP_W-1:0] RND_FIRST = STEP_W'(NUM_IN + 2);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [1:0]  rnd_phase;
    logic        is_rnd;
    logic        unused_ctrl;

    assign is_rnd      = (step_i >= RND_FIRST);
    assign rnd_phase   = 2'(step_i - RND_FIRST);
    assign unused_ctrl = 1'b0;

    // The register advances on every random-step load, so random step r
    // (counted across passes) presents the state reached after r advances.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_i) begin
            lfsr_d = LFSR_SEED;
        end else if (load_i && is_rnd) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        stim_o = walk_stim;
        if (is_rnd) begin
            stim_o = '1;
            if (rnd_phase != 2'd0) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    stim_o[k] = lfsr_q[k % 32];
                end
            end
        end
    end
`else
    logic unused_ctrl;

    assign unused_ctrl = ^{clk, rst, seed_i, load_i};
    assign stim_o      = walk_stim;
`endif

endmodule

// File: rtl/zia_stim_checker.sv
// Stimulus source and response checker for the two-FB ZIA test design.
// Optional LFSR random phase enabled by defining ZIA_STIM_LFSR_EN.
module zia_stim_checker
    import zia_chk_pkg::*;
#(
    parameter int NUM_IN     = 38,
    parameter int SETUP_CYC  = 2,
    parameter int SAMPLE_DLY = 3,
    parameter int NUM_PASSES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic [NUM_IN-1:0]    stim_o,
    output logic                 dut_clk_o,
    input  logic [DUT_OUT_W-1:0] dut_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [7:0]           first_err_step_o,
    output logic [DUT_OUT_W-1:0] first_err_mask_o
);

`ifdef ZIA_STIM_LFSR_EN
    localparam int NUM_STEPS = NUM_IN + 2 + LFSR_STEPS;
`else
    localparam int NUM_STEPS = NUM_IN + 2;
`endif
    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam int FB1_W  = FB1_MSB - FB1_LSB + 1;
    localparam int FB2_W  = FB2_MSB - FB2_LSB + 1;

    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);
    localparam logic [7:0]        SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0]        DLY_LAST   = 8'(SAMPLE_DLY - 1);
    localparam logic [15:0]       PASS_LAST  = 16'(NUM_PASSES - 1);

    chk_state_e           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [15:0]          pass_q, pass_d;
    logic [NUM_IN-1:0]    stim_q, stim_d;
    logic [DUT_OUT_W-1:0] shadow_q, shadow_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]           ferr_step_q, ferr_step_d;
    logic [DUT_OUT_W-1:0] ferr_mask_q, ferr_mask_d;
    logic                 dut_clk_q, dut_clk_d;

    logic [NUM_IN-1:0]    pat_stim;
    logic [DUT_OUT_W-1:0] mask;
    logic                 fb1_en, fb2_en;
    logic                 pat_load, pat_seed;

    assign mask     = dut_out_i ^ shadow_q;
    assign fb1_en   = shadow_q[FB1_FB_BIT] & (&stim_q);
    assign fb2_en   = shadow_q[FB2_FB_BIT] & (&stim_q);
    assign pat_load = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);
    assign pat_seed = (state_q == ST_ALIGN);

    zia_pattern_gen #(
        .NUM_IN (NUM_IN),
        .STEP_W (STEP_W)
    ) u_pattern_gen (
        .clk    (clk),
        .rst    (rst),
        .seed_i (pat_seed),
        .load_i (pat_load),
        .step_i (step_d),
        .stim_o (pat_stim)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        pass_d      = pass_q;
        stim_d      = stim_q;
        shadow_d    = shadow_q;
        err_cnt_d   = err_cnt_q;
        ferr_step_d = ferr_step_q;
        ferr_mask_d = ferr_mask_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d     = ST_ALIGN;
                    cnt_d       = '0;
                    step_d      = '0;
                    pass_d      = '0;
                    err_cnt_d   = '0;
                    ferr_step_d = '0;
                    ferr_mask_d = '0;
                end
            end
            // Adopt whatever the design powered up with as the reference.
            ST_ALIGN: begin
                if (cnt_q == DLY_LAST) begin
                    shadow_d = dut_out_i;
                    cnt_d    = '0;
                    state_d  = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PULSE: begin
                shadow_d[FB1_MSB:FB1_LSB] = {FB1_W{fb1_en}};
                shadow_d[FB2_MSB:FB2_LSB] = {FB2_W{fb2_en}};
                state_d                   = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                // Resync to the observed value so one fault is counted once.
                if (mask != '0) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    shadow_d  = dut_out_i;
                    if (err_cnt_q == '0) begin
                        ferr_step_d = 8'(step_q);
                        ferr_mask_d = mask;
                    end
                end
                state_d = ST_DRIVE;
                if (step_q == LAST_STEP) begin
                    step_d = '0;
                    if (NUM_PASSES != 0) begin
                        if (pass_q == PASS_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            pass_d = pass_q + 16'd1;
                        end
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pat_load) begin
            stim_d = pat_stim;
        end
    end

    assign dut_clk_d = (state_d == ST_PULSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            pass_q      <= '0;
            stim_q      <= '1;
            shadow_q    <= '0;
            err_cnt_q   <= '0;
            ferr_step_q <= '0;
            ferr_mask_q <= '0;
            dut_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            pass_q      <= pass_d;
            stim_q      <= stim_d;
            shadow_q    <= shadow_d;
            err_cnt_q   <= err_cnt_d;
            ferr_step_q <= ferr_step_d;
            ferr_mask_q <= ferr_mask_d;
            dut_clk_q   <= dut_clk_d;
        end
    end

    assign stim_o           = stim_q;
    assign dut_clk_o        = dut_clk_q;
    assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o           = (state_q == ST_DONE);
    assign pass_o           = done_o && (err_cnt_q == '0);
    assign err_cnt_o        = err_cnt_q;
    assign first_err_step_o = ferr_step_q;
    assign first_err_mask_o = ferr_mask_q;

endmodule

// File: tb/tb_zia_stim_checker.sv
// Bench for zia_stim_checker: a behavioural ZIA design with fault injection,
// a run-level result model and a per-strobe stim/strobe-width monitor.
module tb_zia_stim_checker;

    localparam int NI     = 38;
    localparam int NPASS  = 2;
`ifdef ZIA_STIM_LFSR_EN
    localparam int STEPS  = NI + 2 + 32;
`else
    localparam int STEPS  = NI + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NI-1:0] stim;
    logic          dut_clk;
    logic [7:0]    dut_out;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [7:0]    fstep, fmask;

    // Environment: the ZIA design itself, with stuck-at fault controls.
    logic [7:0]    dreg = 8'h00;
    logic [7:0]    pwr_val = 8'h00;
    logic          load_pwr = 1'b0;
    logic          stuck_in1 = 1'b0;
    logic [7:0]    sa0_mask = 8'h00;
    logic [NI-1:0] din;

    int checks = 0;
    int fails  = 0;
    int strobe_idx = 0;

    zia_stim_checker #(
        .NUM_IN     (NI),
        .SETUP_CYC  (2),
        .SAMPLE_DLY (3),
        .NUM_PASSES (NPASS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .stim_o           (stim),
        .dut_clk_o        (dut_clk),
        .dut_out_i        (dut_out),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_cnt_o        (err_cnt),
        .first_err_step_o (fstep),
        .first_err_mask_o (fmask)
    );

    always #5 clk = ~clk;

    assign din     = stim | {{(NI-1){1'b0}}, stuck_in1};
    assign dut_out = dreg & ~sa0_mask;

    always @(posedge clk) begin
        if (load_pwr) begin
            dreg <= pwr_val;
        end else if (dut_clk) begin
            dreg <= {{4{dreg[1] & (&din)}}, {4{dreg[6] & (&din)}}};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] lfsr_at(input int n);
        logic [31:0] s;
        s = 32'hACE1_2345;
        for (int i = 0; i < n; i++) begin
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
        return s;
    endfunction

    // Expected stim for a given pass and step, straight from the pattern rules.
    function automatic logic [NI-1:0] pat(input int p, input int s);
        logic [NI-1:0] v;
        v = '1;
        if (s >= 1 && s <= NI) begin
            v[s-1] = 1'b0;
        end
`ifdef ZIA_STIM_LFSR_EN
        if (s >= NI + 2 && ((s - (NI + 2)) % 4) != 0) begin
            logic [31:0] r;
            r = lfsr_at(p * 32 + (s - (NI + 2)));
            for (int k = 0; k < NI; k++) begin
                v[k] = r[k % 32];
            end
        end
`else
        if (p < 0) begin
            v = '0;
        end
`endif
        return v;
    endfunction

    // Whole-run result: walk every step, apply the FB equations to the real
    // design and to the reference, count mismatches with resync.
    task automatic predict(input logic [7:0] pwr, input logic sin1, input logic [7:0] sa0,
                           output logic [15:0] e, output logic [7:0] fs,
                           output logic [7:0] fm, output logic [7:0] obs0);
        logic [7:0]    d, sh, ob, ex;
        logic [NI-1:0] st, di;
        bit            seen;
        d = pwr; sh = pwr & ~sa0; e = 16'h0; fs = 8'h0; fm = 8'h0; obs0 = 8'h0; seen = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int s = 0; s < STEPS; s++) begin
                st = pat(p, s);
                di = st | {{(NI-1){1'b0}}, sin1};
                d  = {{4{d[1] & (&di)}}, {4{d[6] & (&di)}}};
                ob = d & ~sa0;
                ex = {{4{sh[1] & (&st)}}, {4{sh[6] & (&st)}}};
                if (p == 0 && s == 0) obs0 = ob;
                if (ob != ex) begin
                    if (e != 16'hFFFF) e = e + 16'h1;
                    if (!seen) begin
                        seen = 1; fs = 8'(s); fm = ob ^ ex;
                    end
                    sh = ob;
                end else begin
                    sh = ex;
                end
            end
        end
    endtask

    // Per-strobe monitor: strobe width and stim contents against the pattern model.
    initial begin
        logic prev_dclk, prev_busy;
        logic [NI-1:0] exp_stim;
        prev_dclk = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) strobe_idx = 0;
            if (dut_clk) begin
                chk("dut_clk_width", {31'b0, prev_dclk}, 32'd0);
                exp_stim = pat(strobe_idx / STEPS, strobe_idx % STEPS);
                checks++;
                if (stim !== exp_stim) begin
                    fails++;
                    $display("FAIL stim_strobe%0d actual=%h required=%h", strobe_idx, stim, exp_stim);
                end
                strobe_idx++;
            end
            prev_dclk = dut_clk;
            prev_busy = busy;
        end
    end

    task automatic setup_env(input logic [7:0] pwr, input logic sin1, input logic [7:0] sa0);
        pwr_val = pwr; load_pwr = 1'b1; stuck_in1 = sin1; sa0_mask = sa0;
        @(negedge clk);
        load_pwr = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
    endtask

    task automatic run_case(input string nm, input logic [7:0] pwr, input logic sin1,
                            input logic [7:0] sa0, input bit force_sat);
        logic [15:0] pe;
        logic [7:0]  pfs, pfm, pobs0;
        int n;
        setup_env(pwr, sin1, sa0);
        predict(pwr, sin1, sa0, pe, pfs, pfm, pobs0);
        if (force_sat) pe = (pe >= 16'd1) ? ((pe >= 16'd2) ? 16'hFFFF : 16'hFFFF) : 16'hFFFE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (force_sat) begin
            n = 0;
            while (!dut_clk && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk({nm, "_first_strobe"}, {31'b0, dut_clk}, 32'd1);
            force dut.err_cnt_d = 16'hFFFE;
            @(negedge clk);
            release dut.err_cnt_d;
        end
        wait_done(nm);
        chk({nm, "_err_cnt"}, {16'b0, err_cnt}, {16'b0, pe});
        chk({nm, "_pass"}, {31'b0, pass}, {31'b0, (pe == 16'h0)});
        chk({nm, "_strobes"}, strobe_idx, NPASS * STEPS);
        if (!force_sat) begin
            chk({nm, "_first_step"}, {24'b0, fstep}, {24'b0, pfs});
            chk({nm, "_first_mask"}, {24'b0, fmask}, {24'b0, pfm});
        end
    endtask

    initial begin
        logic [15:0] me;
        logic [7:0]  mfs, mfm, mobs0;
        int n;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pass", {31'b0, pass}, 32'd0);
        chk("rst_dut_clk", {31'b0, dut_clk}, 32'd0);
        chk("rst_stim_ones", {31'b0, (&stim)}, 32'd1);
        chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        chk("rst_first", {16'b0, fstep, fmask}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Hand-computed pins on the result model.
        predict(8'hE5, 1'b0, 8'h00, me, mfs, mfm, mobs0);
        chk("model_clean_err", {16'b0, me}, 32'd0);
        chk("model_clean_step0", {24'b0, mobs0}, 32'h0F);
        predict(8'hE5, 1'b1, 8'h00, me, mfs, mfm, mobs0);
        chk("model_in1_sa1", {me, mfs, mfm}, {16'd1, 8'd1, 8'hF0});
        predict(8'hE7, 1'b0, 8'h20, me, mfs, mfm, mobs0);
        chk("model_out5_sa0", {me, mfs, mfm}, {16'd1, 8'd0, 8'h20});

        run_case("clean", 8'hE5, 1'b0, 8'h00, 1'b0);
        chk("clean_final_out", {24'b0, dut_out}, 32'h00);
        run_case("in1_sa1", 8'hE5, 1'b1, 8'h00, 1'b0);
        chk("in1_sa1_lit", {err_cnt, fstep, fmask}, {16'd1, 8'd1, 8'hF0});
        run_case("out5_sa0", 8'hE7, 1'b0, 8'h20, 1'b0);
        chk("out5_sa0_lit", {err_cnt, fstep, fmask}, {16'd1, 8'd0, 8'h20});
        run_case("saturate", 8'hE7, 1'b1, 8'h20, 1'b1);
        chk("saturate_lit", {16'b0, err_cnt}, 32'hFFFF);

        // Reset in the WAIT phase of step 5.
        setup_env(8'hE5, 1'b1, 8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (strobe_idx < 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached", {31'b0, (strobe_idx >= 6)}, 32'd1);
        @(negedge clk);
        chk("midrst_err_before", {16'b0, err_cnt}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_dut_clk", {31'b0, dut_clk}, 32'd0);
        chk("midrst_stim", {31'b0, (&stim)}, 32'd1);
        chk("midrst_err", {16'b0, err_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_case("after_rst", 8'hE5, 1'b0, 8'h00, 1'b0);

        // start held high through DONE restarts immediately.
        setup_env(8'h00, 1'b0, 8'h00);
        start = 1'b1;
        @(negedge clk);
        wait_done("held");
        chk("held_strobes", strobe_idx, NPASS * STEPS);
        @(negedge clk);
        chk("held_restart", {30'b0, done, busy}, 32'd1);
        start = 1'b0;
        wait_done("held_second");
        chk("held_second_pass", {31'b0, pass}, 32'd1);
        chk("held_second_strobes", strobe_idx, NPASS * STEPS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
